// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : knn_pkg
// Description : Shared definitions for the k-nearest-neighbour classifier:
//               FSM state encoding, distance-width function and slice helper.
// Revision    : 1.0 - initial release
// ============================================================================
package knn_pkg;

    // FSM state encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ACCUM = 3'd1;
    localparam logic [2:0] c_ST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_VOTE  = 3'd3;
    localparam logic [2:0] c_ST_SCAN  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    // Width that holds a sum of DIMS squared (COORD_W+1)-bit differences
    // without overflow. A single dimension still keeps one guard bit.
    function automatic int dist_w(input int coord_w, input int dims);
        int extra;
        extra = (dims <= 1) ? 1 : $clog2(dims);
        return 2 * coord_w + 1 + extra;
    endfunction

    // LSB position of element idx inside a packed vector of width-wide slices.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/knn_dist_pipe.sv
`default_nettype none
// ============================================================================
// Module      : knn_dist_pipe
// Description : Two-stage squared Euclidean distance pipeline.
//               S1 registers the per-dimension squared differences,
//               S2 registers their sum. Label and valid ride alongside.
//               i_flush kills every in-flight sample.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_flush            - drop all in-flight samples
//               i_valid            - sample enters S1 this cycle
//               i_test_point       - reference point (dim 0 at LSBs)
//               i_sample_point     - training point  (dim 0 at LSBs)
//               i_label            - training label
//               o_valid/o_dist/o_label - S2 result
//               o_busy             - any stage holds a valid sample
// Revision    : 1.0 - initial release
// ============================================================================
module knn_dist_pipe
    import knn_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int DIMS    = 2,
    parameter int LABEL_W = 8,
    parameter int DIST_W  = dist_w(COORD_W, DIMS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  logic [DIMS*COORD_W-1:0] i_test_point,
    input  logic [DIMS*COORD_W-1:0] i_sample_point,
    input  logic [LABEL_W-1:0]      i_label,
    output logic                    o_valid,
    output logic [DIST_W-1:0]       o_dist,
    output logic [LABEL_W-1:0]      o_label,
    output logic                    o_busy
);

    localparam int c_SQ_W = 2 * COORD_W + 2;

    logic [DIST_W-1:0]  w_sq [DIMS];
    logic [DIST_W-1:0]  r_sq [DIMS];
    logic [DIST_W-1:0]  w_sum;
    logic               r_s1_valid;
    logic [LABEL_W-1:0] r_s1_label;
    logic               r_s2_valid;
    logic [DIST_W-1:0]  r_s2_dist;
    logic [LABEL_W-1:0] r_s2_label;

    genvar gd;
    for (gd = 0; gd < DIMS; gd++) begin : g_dim
        localparam int c_LO = slice_lo(gd, COORD_W);
        logic [COORD_W-1:0]      w_a;
        logic [COORD_W-1:0]      w_b;
        logic signed [COORD_W:0] w_diff;
        logic signed [c_SQ_W-1:0] w_prod;
        assign w_a    = i_sample_point[c_LO +: COORD_W];
        assign w_b    = i_test_point[c_LO +: COORD_W];
        // Sign-extend by one bit so the difference of two extremes fits.
        assign w_diff = {w_a[COORD_W-1], w_a} - {w_b[COORD_W-1], w_b};
        assign w_prod = w_diff * w_diff;
        // A square is never negative, so the extension cannot go wrong.
        assign w_sq[gd] = DIST_W'(w_prod);
    end

    always_comb begin
        w_sum = '0;
        for (int d = 0; d < DIMS; d++) begin
            w_sum = w_sum + r_sq[d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_label <= '0;
            r_s2_valid <= 1'b0;
            r_s2_dist  <= '0;
            r_s2_label <= '0;
            for (int d = 0; d < DIMS; d++) begin
                r_sq[d] <= '0;
            end
        end else begin
            r_s1_valid <= i_valid & ~i_flush;
            r_s2_valid <= r_s1_valid & ~i_flush;
            if (i_valid) begin
                r_s1_label <= i_label;
                for (int d = 0; d < DIMS; d++) begin
                    r_sq[d] <= w_sq[d];
                end
            end
            if (r_s1_valid) begin
                r_s2_dist  <= w_sum;
                r_s2_label <= r_s1_label;
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_dist  = r_s2_dist;
    assign o_label = r_s2_label;
    assign o_busy  = r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: rtl/knn_classifier.sv
`default_nettype none
// ============================================================================
// Module      : knn_classifier
// Description : k-nearest-neighbour engine. Streams labelled samples through
//               a distance pipeline against a latched test point, keeps a
//               sorted list of the K nearest, then runs a majority vote.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - latch test_point, clear list, accumulate
//               test_point          - reference point (dim 0 at LSBs)
//               sample_valid/ready  - training sample handshake
//               sample_point/label  - training sample
//               classify            - finish accumulation and vote
//               busy                - draining / voting / scanning
//               result_valid/label/none - vote outcome
//               nbr_count/dists/labels  - neighbour list (entry 0 at LSBs)
// Revision    : 1.0 - initial release
// ============================================================================
module knn_classifier
    import knn_pkg::*;
#(
    parameter int COORD_W   = 16,
    parameter int DIMS      = 2,
    parameter int K         = 10,
    parameter int LABEL_W   = 8,
    parameter int N_CLASSES = 16,
    localparam int DIST_W   = dist_w(COORD_W, DIMS),
    localparam int CNT_W    = $clog2(K + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIMS*COORD_W-1:0] test_point,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [DIMS*COORD_W-1:0] sample_point,
    input  logic [LABEL_W-1:0]      sample_label,
    input  logic                    classify,
    output logic                    busy,
    output logic                    result_valid,
    output logic [LABEL_W-1:0]      result_label,
    output logic                    result_none,
    output logic [CNT_W-1:0]        nbr_count,
    output logic [K*DIST_W-1:0]     nbr_dists,
    output logic [K*LABEL_W-1:0]    nbr_labels
);

    localparam int c_IDX_W = $clog2(((K > N_CLASSES) ? K : N_CLASSES) + 1);

    logic [2:0]                r_state;
    logic [2:0]                w_state_nx;
    logic                      w_start_ok;
    logic [DIMS*COORD_W-1:0]   r_test_point;

    logic                      w_p_valid;
    logic [DIST_W-1:0]         w_p_dist;
    logic [LABEL_W-1:0]        w_p_label;
    logic                      w_p_busy;

    logic [K-1:0]              r_valid;
    logic [DIST_W-1:0]         r_dist  [K];
    logic [LABEL_W-1:0]        r_label [K];
    logic [CNT_W-1:0]          r_count;
    logic [K-1:0]              w_lt;
    logic [K-1:0]              w_nx_valid;
    logic [DIST_W-1:0]         w_nx_dist  [K];
    logic [LABEL_W-1:0]        w_nx_label [K];

    logic [CNT_W-1:0]          r_votes [N_CLASSES];
    logic [c_IDX_W-1:0]        r_idx;
    logic [LABEL_W-1:0]        r_best_label;
    logic [CNT_W-1:0]          r_best_cnt;
    logic                      w_sel_valid;
    logic [LABEL_W-1:0]        w_sel_label;
    logic [CNT_W-1:0]          w_sel_votes;

    logic [CNT_W-1:0]          r_nbr_count;
    logic [K*DIST_W-1:0]       r_nbr_dists;
    logic [K*LABEL_W-1:0]      r_nbr_labels;

    assign w_start_ok = start & ((r_state == c_ST_IDLE) | (r_state == c_ST_ACCUM) |
                                 (r_state == c_ST_DONE));

    knn_dist_pipe #(
        .COORD_W (COORD_W),
        .DIMS    (DIMS),
        .LABEL_W (LABEL_W),
        .DIST_W  (DIST_W)
    ) u_pipe (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (w_start_ok),
        .i_valid        (sample_valid & sample_ready),
        .i_test_point   (r_test_point),
        .i_sample_point (sample_point),
        .i_label        (sample_label),
        .o_valid        (w_p_valid),
        .o_dist         (w_p_dist),
        .o_label        (w_p_label),
        .o_busy         (w_p_busy)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nx = c_ST_ACCUM;
            c_ST_ACCUM: begin
                if (start)         w_state_nx = c_ST_ACCUM;
                else if (classify) w_state_nx = c_ST_DRAIN;
            end
            c_ST_DRAIN: if (!w_p_busy) w_state_nx = c_ST_VOTE;
            c_ST_VOTE:  if (r_idx == c_IDX_W'(K - 1)) w_state_nx = c_ST_SCAN;
            c_ST_SCAN:  if (r_idx == c_IDX_W'(N_CLASSES - 1)) w_state_nx = c_ST_DONE;
            c_ST_DONE:  if (start) w_state_nx = c_ST_ACCUM;
            default:    w_state_nx = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        sample_ready = (r_state == c_ST_ACCUM) & ~start & ~classify;
        busy         = (r_state == c_ST_DRAIN) | (r_state == c_ST_VOTE) |
                       (r_state == c_ST_SCAN);
        result_valid = (r_state == c_ST_DONE);
        result_none  = (r_state == c_ST_DONE) & (r_best_cnt == '0);
        result_label = (r_state == c_ST_DONE) ? r_best_label : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)             r_test_point <= '0;
        else if (w_start_ok) r_test_point <= test_point;
    end

    // ---------------- Sorted neighbour list ----------------
    // w_lt is monotone over the sorted list: once the new distance beats an
    // entry it beats every later one. Each beaten entry takes its
    // predecessor's contents, except the first beaten one, which takes the
    // new sample. Strict '<' keeps equal-distance older entries ahead.
    genvar gi;
    for (gi = 0; gi < K; gi++) begin : g_entry
        assign w_lt[gi] = ~r_valid[gi] | (w_p_dist < r_dist[gi]);
        if (gi == 0) begin : g_head
            assign w_nx_dist[gi]  = w_p_dist;
            assign w_nx_label[gi] = w_p_label;
            assign w_nx_valid[gi] = 1'b1;
        end else begin : g_tail
            assign w_nx_dist[gi]  = w_lt[gi-1] ? r_dist[gi-1]  : w_p_dist;
            assign w_nx_label[gi] = w_lt[gi-1] ? r_label[gi-1] : w_p_label;
            assign w_nx_valid[gi] = w_lt[gi-1] ? r_valid[gi-1] : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < K; i++) begin
                r_dist[i]  <= '0;
                r_label[i] <= '0;
            end
        end else if (w_start_ok) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (w_p_valid) begin
            for (int i = 0; i < K; i++) begin
                if (w_lt[i]) begin
                    r_dist[i]  <= w_nx_dist[i];
                    r_label[i] <= w_nx_label[i];
                    r_valid[i] <= w_nx_valid[i];
                end
            end
            if ((|w_lt) && (r_count != CNT_W'(K))) r_count <= r_count + CNT_W'(1);
        end
    end

    // ---------------- Vote ----------------
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_label = '0;
        w_sel_votes = '0;
        for (int i = 0; i < K; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_sel_valid = r_valid[i];
                w_sel_label = r_label[i];
            end
        end
        for (int c = 0; c < N_CLASSES; c++) begin
            if (r_idx == c_IDX_W'(c)) w_sel_votes = r_votes[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_idx        <= '0;
            r_best_label <= '0;
            r_best_cnt   <= '0;
            for (int c = 0; c < N_CLASSES; c++) begin
                r_votes[c] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_VOTE: begin
                    r_idx <= (r_idx == c_IDX_W'(K - 1)) ? '0 : r_idx + c_IDX_W'(1);
                    // Labels at or above N_CLASSES match no counter.
                    for (int c = 0; c < N_CLASSES; c++) begin
                        if (w_sel_valid && (w_sel_label == LABEL_W'(c)))
                            r_votes[c] <= r_votes[c] + CNT_W'(1);
                    end
                end
                c_ST_SCAN: begin
                    r_idx <= r_idx + c_IDX_W'(1);
                    // Strictly greater: ties keep the lower class index.
                    if (w_sel_votes > r_best_cnt) begin
                        r_best_cnt   <= w_sel_votes;
                        r_best_label <= LABEL_W'(r_idx);
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // ---------------- Registered list view ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nbr_count  <= '0;
            r_nbr_dists  <= '0;
            r_nbr_labels <= '0;
        end else begin
            r_nbr_count <= r_count;
            for (int i = 0; i < K; i++) begin
                r_nbr_dists[slice_lo(i, DIST_W) +: DIST_W]   <= r_valid[i] ? r_dist[i]  : '0;
                r_nbr_labels[slice_lo(i, LABEL_W) +: LABEL_W] <= r_valid[i] ? r_label[i] : '0;
            end
        end
    end

    assign nbr_count  = r_nbr_count;
    assign nbr_dists  = r_nbr_dists;
    assign nbr_labels = r_nbr_labels;

endmodule
`default_nettype wire

// File: tb/tb_knn_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_classifier
// Description : Self-checking bench for knn_classifier (K=4, 2-D, 16-bit).
//               Reference model: stable sorted list of the K nearest samples
//               and a plain label histogram vote.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_classifier;

    localparam int COORD_W   = 16;
    localparam int DIMS      = 2;
    localparam int K         = 4;
    localparam int LABEL_W   = 8;
    localparam int N_CLASSES = 16;
    localparam int DIST_W    = 2 * COORD_W + 2;
    localparam int CNT_W     = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [DIMS*COORD_W-1:0] test_point;
    logic                    sample_valid;
    logic                    sample_ready;
    logic [DIMS*COORD_W-1:0] sample_point;
    logic [LABEL_W-1:0]      sample_label;
    logic                    classify;
    logic                    busy;
    logic                    result_valid;
    logic [LABEL_W-1:0]      result_label;
    logic                    result_none;
    logic [CNT_W-1:0]        nbr_count;
    logic [K*DIST_W-1:0]     nbr_dists;
    logic [K*LABEL_W-1:0]    nbr_labels;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint m_d[$];
    int     m_l[$];
    int     tx, ty;

    always #5 clk = ~clk;

    knn_classifier #(
        .COORD_W   (COORD_W),
        .DIMS      (DIMS),
        .K         (K),
        .LABEL_W   (LABEL_W),
        .N_CLASSES (N_CLASSES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .test_point   (test_point),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_point (sample_point),
        .sample_label (sample_label),
        .classify     (classify),
        .busy         (busy),
        .result_valid (result_valid),
        .result_label (result_label),
        .result_none  (result_none),
        .nbr_count    (nbr_count),
        .nbr_dists    (nbr_dists),
        .nbr_labels   (nbr_labels)
    );

    // ---------------- reference model ----------------
    function automatic longint sqdist(int ax, int ay, int bx, int by);
        longint dx, dy;
        dx = longint'(ax) - longint'(bx);
        dy = longint'(ay) - longint'(by);
        return dx * dx + dy * dy;
    endfunction

    // Keep the K smallest distances, arrival order among equals.
    function automatic void model_add(longint d, int l);
        int pos;
        pos = m_d.size();
        for (int i = m_d.size() - 1; i >= 0; i--) if (d < m_d[i]) pos = i;
        if (pos < K) begin
            m_d.insert(pos, d);
            m_l.insert(pos, l);
            if (m_d.size() > K) begin
                void'(m_d.pop_back());
                void'(m_l.pop_back());
            end
        end
    endfunction

    function automatic int model_vote(output bit none);
        int cnt[N_CLASSES];
        int best, bc;
        best = 0;
        bc   = 0;
        foreach (cnt[c]) cnt[c] = 0;
        foreach (m_l[i]) if (m_l[i] < N_CLASSES) cnt[m_l[i]]++;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (cnt[c] > bc) begin
                bc   = cnt[c];
                best = c;
            end
        end
        none = (bc == 0);
        return best;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_start(int x, int y);
        @(negedge clk);
        sample_valid = 1'b0;
        classify     = 1'b0;
        start        = 1'b1;
        test_point   = {16'(y), 16'(x)};
        tx = x;
        ty = y;
        m_d.delete();
        m_l.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(int x, int y, int l);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_point = {16'(y), 16'(x)};
        sample_label = 8'(l);
        @(posedge clk);
        model_add(sqdist(x, y, tx, ty), l);
    endtask

    task automatic end_samples();
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic do_classify();
        @(negedge clk);
        sample_valid = 1'b0;
        classify     = 1'b1;
        @(negedge clk);
        classify = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (result_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: result_valid=%b after %0d cycles, required 1", result_valid, cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sample_ready, busy, result_valid, result_none} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: ready/busy/valid/none=%b required 0000",
                     {sample_ready, busy, result_valid, result_none});
        end
        checks++;
        if (result_label !== '0 || nbr_count !== '0) begin
            errors++;
            $display("FAIL reset_label_count: label=%0d count=%0d required 0", result_label, nbr_count);
        end
        checks++;
        if (nbr_dists !== '0 || nbr_labels !== '0) begin
            errors++;
            $display("FAIL reset_list: dists=%h labels=%h required 0", nbr_dists, nbr_labels);
        end
        rst = 1'b0;
    endtask

    task automatic test_sort_tiebreak();
        longint exp_d[4] = '{2, 4, 25, 25};
        int     exp_l[4] = '{2, 2, 1, 3};
        int     cyc;
        do_start(0, 0);
        send(3, 4, 1);
        send(1, 1, 2);
        send(5, 0, 3);
        send(0, 2, 2);
        send(10, 10, 5);
        end_samples();
        repeat (3) @(negedge clk);
        checks++;
        if (nbr_count !== 3'd4) begin
            errors++;
            $display("FAIL sort_count: got %0d required 4", nbr_count);
        end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (nbr_dists[i*DIST_W +: DIST_W] !== DIST_W'(exp_d[i]) ||
                nbr_labels[i*LABEL_W +: LABEL_W] !== LABEL_W'(exp_l[i])) begin
                errors++;
                $display("FAIL sort_entry[%0d]: got d=%0d l=%0d required d=%0d l=%0d", i,
                         nbr_dists[i*DIST_W +: DIST_W], nbr_labels[i*LABEL_W +: LABEL_W],
                         exp_d[i], exp_l[i]);
            end
        end
        do_classify();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sort_busy: got %b required 1", busy);
        end
        wait_done(cyc);
        checks++;
        if (result_label !== 8'd2 || result_none !== 1'b0) begin
            errors++;
            $display("FAIL sort_vote: got label=%0d none=%b required label=2 none=0",
                     result_label, result_none);
        end
        checks++;
        if (cyc < K + N_CLASSES + 1 || cyc > K + N_CLASSES + 4) begin
            errors++;
            $display("FAIL vote_latency: got %0d cycles required %0d..%0d", cyc,
                     K + N_CLASSES + 1, K + N_CLASSES + 4);
        end
    endtask

    task automatic test_vote_tie();
        int cyc;
        do_start(0, 0);
        send(1, 0, 3);
        send(1, 1, 3);
        send(2, 0, 1);
        send(2, 1, 1);
        end_samples();
        do_classify();
        wait_done(cyc);
        checks++;
        if (result_label !== 8'd1) begin
            errors++;
            $display("FAIL vote_tie: got %0d required 1", result_label);
        end
    endtask

    task automatic test_extremes();
        longint exp_d;
        exp_d = 64'd8589672450;
        do_start(-32768, -32768);
        send(32767, 32767, 7);
        end_samples();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (nbr_count !== 3'd0) begin
            errors++;
            $display("FAIL extreme_early: count=%0d two edges after accept, required 0", nbr_count);
        end
        @(negedge clk);
        checks++;
        if (nbr_count !== 3'd1 || nbr_dists[DIST_W-1:0] !== DIST_W'(exp_d) ||
            nbr_labels[LABEL_W-1:0] !== 8'd7) begin
            errors++;
            $display("FAIL extreme_dist: count=%0d d=%0d l=%0d required count=1 d=%0d l=7",
                     nbr_count, nbr_dists[DIST_W-1:0], nbr_labels[LABEL_W-1:0], exp_d);
        end
    endtask

    task automatic test_restart();
        do_start(0, 0);
        send(1, 2, 4);
        send(3, 3, 5);
        do_start(9, 9);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (nbr_count !== 3'd0 || nbr_dists !== '0) begin
                errors++;
                $display("FAIL restart[%0d]: count=%0d dists=%h required 0", i, nbr_count, nbr_dists);
            end
            @(negedge clk);
        end
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_ready: got %b required 1", sample_ready);
        end
    endtask

    task automatic test_partial();
        int cyc, exp_lab;
        bit exp_none;
        do_start(5, -5);
        send(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10,
             int'($urandom_range(0, N_CLASSES - 1)));
        send(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10,
             int'($urandom_range(0, N_CLASSES - 1)));
        end_samples();
        do_classify();
        wait_done(cyc);
        exp_lab = model_vote(exp_none);
        checks++;
        if (nbr_count !== 3'd2) begin
            errors++;
            $display("FAIL partial_count: got %0d required 2", nbr_count);
        end
        checks++;
        if (result_label !== 8'(exp_lab) || result_none !== exp_none) begin
            errors++;
            $display("FAIL partial_vote: got label=%0d none=%b required label=%0d none=%b",
                     result_label, result_none, exp_lab, exp_none);
        end
    endtask

    task automatic test_empty();
        int cyc;
        do_start(0, 0);
        do_classify();
        wait_done(cyc);
        checks++;
        if (result_valid !== 1'b1 || result_none !== 1'b1 || result_label !== 8'd0) begin
            errors++;
            $display("FAIL empty_vote: valid=%b none=%b label=%0d required 1 1 0",
                     result_valid, result_none, result_label);
        end
    endtask

    task automatic test_midreset();
        do_start(1, 1);
        send(2, 2, 3);
        send(4, 4, 6);
        end_samples();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (nbr_count !== 3'd0 || sample_ready !== 1'b0 || nbr_dists !== '0) begin
            errors++;
            $display("FAIL midreset: count=%0d ready=%b dists=%h required 0 0 0",
                     nbr_count, sample_ready, nbr_dists);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int cyc, n, x, y, exp_lab;
        bit wide, exp_none;
        longint ed;
        int el;
        for (int r = 0; r < 12; r++) begin
            wide = ($urandom_range(0, 3) == 0);
            x = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16)) - 8;
            y = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16)) - 8;
            do_start(x, y);
            n = int'($urandom_range(0, 9));
            for (int s = 0; s < n; s++) begin
                x = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16)) - 8;
                y = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16)) - 8;
                send(x, y, int'($urandom_range(0, 19)));
            end
            end_samples();
            repeat (3) @(negedge clk);
            checks++;
            if (nbr_count !== CNT_W'(m_d.size())) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d required %0d", r, nbr_count, m_d.size());
            end
            for (int i = 0; i < K; i++) begin
                ed = (i < m_d.size()) ? m_d[i] : 0;
                el = (i < m_l.size()) ? m_l[i] : 0;
                checks++;
                if (nbr_dists[i*DIST_W +: DIST_W] !== DIST_W'(ed) ||
                    nbr_labels[i*LABEL_W +: LABEL_W] !== LABEL_W'(el)) begin
                    errors++;
                    $display("FAIL rand%0d_entry[%0d]: got d=%0d l=%0d required d=%0d l=%0d", r, i,
                             nbr_dists[i*DIST_W +: DIST_W], nbr_labels[i*LABEL_W +: LABEL_W], ed, el);
                end
            end
            do_classify();
            wait_done(cyc);
            exp_lab = model_vote(exp_none);
            checks++;
            if (result_label !== 8'(exp_lab) || result_none !== exp_none) begin
                errors++;
                $display("FAIL rand%0d_vote: got label=%0d none=%b required label=%0d none=%b", r,
                         result_label, result_none, exp_lab, exp_none);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        classify     = 1'b0;
        sample_valid = 1'b0;
        test_point   = '0;
        sample_point = '0;
        sample_label = '0;
        test_reset();
        test_sort_tiebreak();
        test_vote_tie();
        test_extremes();
        test_restart();
        test_partial();
        test_empty();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
